// File: rtl/datamem_responder.sv
// Byte-addressed big-endian data-memory target with valid/ready request and response channels.
// Optional macro DATAMEM_PERF_CNT_EN adds saturating successful-load/store counters.
module datamem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
`ifdef DATAMEM_PERF_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [3:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        size_ok, align_ok, range_ok, legal, access;
  logic [AW:0] end_addr;
  logic [63:0] rd_word;

  // Range check is done in AW+1 bits on the low address once the high bits are known zero,
  // so a huge address can never wrap back into range.
  assign size_ok  = (size_q == 4'd1) || (size_q == 4'd2) || (size_q == 4'd4) || (size_q == 4'd8);
  assign align_ok = (addr_q[3:0] & (size_q - 4'd1)) == 4'd0;
  assign end_addr = {1'b0, addr_q[AW-1:0]} + (AW+1)'(size_q);
  assign range_ok = (addr_q[63:AW] == '0) && (end_addr <= (AW+1)'(DEPTH_BYTES));
  assign legal    = size_ok && align_ok && range_ok;
  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);

  // Lowest address is the most significant byte of the right-justified word.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(size_q)) rd_word = {rd_word[55:0], mem[addr_q[AW-1:0] + AW'(i)]};
    end
  end

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        addr_d  = req_addr;
        size_d  = req_size;
        wdata_d = req_wdata;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = BUSY;
      end
      BUSY: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        err_d   = !legal;
        rdata_d = (legal && !write_q) ? rd_word : 64'd0;
        state_d = RESP;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array has no reset; an aborted request never reaches its access edge.
  always_ff @(posedge clk) begin
    if (access && write_q && legal) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(size_q))
          mem[addr_q[AW-1:0] + AW'(i)] <= wdata_q[8*(int'(size_q)-1-i) +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE) && reset;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

`ifdef DATAMEM_PERF_CNT_EN
  logic [31:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (access && legal) begin
      if (!write_q && rd_count_q != '1) rd_count_q <= rd_count_q + 32'd1;
      if (write_q && wr_count_q != '1) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_datamem_responder.sv
// Directed self-checking bench for datamem_responder (DEPTH_BYTES=1024, WAIT_CYCLES=2).
module tb_datamem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
`ifdef DATAMEM_PERF_CNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  datamem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef DATAMEM_PERF_CNT_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h want 0x%016h", tag, act, exp);
    end
  endtask

  task automatic wait_resp(input string tag);
    int lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(WAITC + 1));
  endtask

  task automatic txn(input string tag, input logic wr, input logic [63:0] addr,
                     input logic [3:0] size, input logic [63:0] wdata,
                     input logic [63:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    check({tag, ":ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    wait_resp(tag);
    @(negedge clk);
    check({tag, ":err"}, 64'(resp_err), 64'(exp_err));
    check({tag, ":rdata"}, resp_rdata, exp_rdata);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, ":valid_clr"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic seen;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_size   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    #12;
    check("rst:ready", 64'(req_ready), 64'd0);
    check("rst:valid", 64'(resp_valid), 64'd0);
    check("rst:rdata", resp_rdata, 64'd0);
    check("rst:err", 64'(resp_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel:ready", 64'(req_ready), 64'd1);

    txn("st_dw", 1'b1, 64'h10, 4'd8, 64'h0123456789ABCDEF, 64'd0, 1'b0);
    txn("ld_dw", 1'b0, 64'h10, 4'd8, 64'd0, 64'h0123456789ABCDEF, 1'b0);
    txn("ld_b0", 1'b0, 64'h10, 4'd1, 64'd0, 64'h01, 1'b0);
    txn("ld_b7", 1'b0, 64'h17, 4'd1, 64'd0, 64'hEF, 1'b0);
    txn("ld_w",  1'b0, 64'h14, 4'd4, 64'd0, 64'h89ABCDEF, 1'b0);
    txn("ld_h",  1'b0, 64'h12, 4'd2, 64'd0, 64'h4567, 1'b0);

    txn("st_b",  1'b1, 64'h13, 4'd1, 64'hFFFF_FFFF_FFFF_FF5A, 64'd0, 1'b0);
    txn("ld_mrg", 1'b0, 64'h10, 4'd8, 64'd0, 64'h0123455A89ABCDEF, 1'b0);

    txn("st_top", 1'b1, 64'(DEPTH - 8), 4'd8, 64'h1122334455667788, 64'd0, 1'b0);
    txn("ld_top", 1'b0, 64'(DEPTH - 4), 4'd4, 64'd0, 64'h55667788, 1'b0);

    txn("e_mis",  1'b0, 64'h12, 4'd8, 64'd0, 64'd0, 1'b1);
    txn("e_mis_st", 1'b1, 64'h12, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    txn("e_size", 1'b1, 64'h10, 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    txn("e_oor",  1'b1, 64'(DEPTH - 4), 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    txn("e_wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    txn("chk_lo", 1'b0, 64'h10, 4'd8, 64'd0, 64'h0123455A89ABCDEF, 1'b0);
    txn("chk_hi", 1'b0, 64'(DEPTH - 8), 4'd8, 64'd0, 64'h1122334455667788, 1'b0);

    // Backpressure: response held for five cycles, with a request pulse that must be ignored.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h10;
    req_size  = 4'd8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_resp("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp:valid", 64'(resp_valid), 64'd1);
      check("bp:rdata", resp_rdata, 64'h0123455A89ABCDEF);
      check("bp:ready", 64'(req_ready), 64'd0);
      if (k == 2) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 64'd0;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("bp:valid_clr", 64'(resp_valid), 64'd0);
    check("bp:idle_ready", 64'(req_ready), 64'd1);
    txn("bp_reload", 1'b0, 64'h10, 4'd8, 64'd0, 64'h0123455A89ABCDEF, 1'b0);

`ifdef DATAMEM_PERF_CNT_EN
    check("perf:rd", 64'(rd_count), 64'd11);
    check("perf:wr", 64'(wr_count), 64'd3);
`endif

    // Reset during BUSY, one edge before the access edge of a store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h10;
    req_size  = 4'd8;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort:valid", 64'(resp_valid), 64'd0);
    check("abort:ready", 64'(req_ready), 64'd0);
`ifdef DATAMEM_PERF_CNT_EN
    check("abort:perf_rd", 64'(rd_count), 64'd0);
    check("abort:perf_wr", 64'(wr_count), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort:rel_ready", 64'(req_ready), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("abort:no_resp", 64'(seen), 64'd0);
    txn("abort_reload", 1'b0, 64'h10, 4'd8, 64'd0, 64'h0123455A89ABCDEF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
